pipe_hazard_ctrl: RTL and testbench

Parametrised hazard and pipeline-control unit for the five-stage RV64 pipeline (IF/ID/EX/MEM/WB). Keeps its own shadow copy of destination/source info for the ID/EX, EX/MEM and MEM/WB registers and drives the control signals the existing pipeline does not have:
- EX-operand forwarding selects, plus an ID-stage write-through bypass.
- Load-use interlock, with a bubble inserted into ID/EX.
- Taken-branch flush.
- Whole-pipe freeze on memory busy.
- Saturating stall/flush performance counters.

---
 rtl/pipe_hazard_ctrl_if.sv | 39 +++
 rtl/pipe_hazard_ctrl.sv | 82 ++++++++
 tb/tb_pipe_hazard_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: ID-stage hazard inputs and pipeline-control outputs.
interface pipe_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              ex_branch_taken;
  logic              mem_busy;
  logic              stall_if;
  logic              stall_id;
  logic              bubble_ex;
  logic              flush_ifid;
  logic              flush_idex;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              id_byp_a;
  logic              id_byp_b;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;
  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2, id_reg_write, id_mem_read,
           ex_branch_taken, mem_busy,
    input  stall_if, stall_id, bubble_ex, flush_ifid, flush_idex, fwd_a, fwd_b, id_byp_a, id_byp_b,
           stall_cnt, flush_cnt
  );
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2, id_reg_write, id_mem_read,
           ex_branch_taken, mem_busy,
    output stall_if, stall_id, bubble_ex, flush_ifid, flush_idex, fwd_a, fwd_b, id_byp_a, id_byp_b,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: forwarding, load-use/RAW interlock, branch flush and freeze control for a 5-stage pipe.
module pipe_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16
) (
  input logic clk,
  input logic reset,
  pipe_hazard_ctrl_if.slave bus
);
  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic              rw;
    logic              mr;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              u1;
    logic              u2;
  } stg_t;
  localparam logic [CNT_W-1:0] CMAX = '1;
  stg_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic ex_wr, mem_wr, wb_wr, lu, il, h, fl, hz;
  logic unused_wb;
  function automatic logic hit(input logic [REG_AW-1:0] rd, input logic [REG_AW-1:0] rs1,
                               input logic [REG_AW-1:0] rs2, input logic u1, input logic u2);
    return (u1 && rd == rs1) || (u2 && rd == rs2);
  endfunction
  assign unused_wb = ^{wb_q.mr, wb_q.rs1, wb_q.rs2, wb_q.u1, wb_q.u2};
  always_comb begin
    ex_wr  = ex_q.v && ex_q.rw && ex_q.rd != '0;
    mem_wr = mem_q.v && mem_q.rw && mem_q.rd != '0;
    wb_wr  = wb_q.v && wb_q.rw && wb_q.rd != '0;
    lu = bus.id_valid && ex_wr && ex_q.mr
         && hit(ex_q.rd, bus.id_rs1, bus.id_rs2, bus.id_use_rs1, bus.id_use_rs2);
    il = bus.id_valid
         && ((ex_wr && hit(ex_q.rd, bus.id_rs1, bus.id_rs2, bus.id_use_rs1, bus.id_use_rs2))
          || (mem_wr && hit(mem_q.rd, bus.id_rs1, bus.id_rs2, bus.id_use_rs1, bus.id_use_rs2)));
    h  = (FWD_EN != 0) ? lu : il;
    // freeze outranks flush: a held branch re-presents its flush once memory is ready
    fl = !bus.mem_busy && bus.ex_branch_taken;
    hz = !bus.mem_busy && !bus.ex_branch_taken && h;
    bus.stall_if   = bus.mem_busy || hz;
    bus.stall_id   = bus.mem_busy || hz;
    bus.bubble_ex  = hz;
    bus.flush_ifid = fl;
    bus.flush_idex = fl;
    bus.fwd_a = (FWD_EN == 0) ? 2'b00
              : (mem_wr && ex_q.u1 && mem_q.rd == ex_q.rs1) ? 2'b10
              : (wb_wr && ex_q.u1 && wb_q.rd == ex_q.rs1) ? 2'b01 : 2'b00;
    bus.fwd_b = (FWD_EN == 0) ? 2'b00
              : (mem_wr && ex_q.u2 && mem_q.rd == ex_q.rs2) ? 2'b10
              : (wb_wr && ex_q.u2 && wb_q.rd == ex_q.rs2) ? 2'b01 : 2'b00;
    bus.id_byp_a  = wb_wr && bus.id_use_rs1 && wb_q.rd == bus.id_rs1;
    bus.id_byp_b  = wb_wr && bus.id_use_rs2 && wb_q.rd == bus.id_rs2;
    bus.stall_cnt = stall_cnt_q;
    bus.flush_cnt = flush_cnt_q;
    ex_d  = bus.mem_busy ? ex_q : (fl || hz) ? '0
          : {bus.id_valid, bus.id_rd, bus.id_reg_write, bus.id_mem_read,
             bus.id_rs1, bus.id_rs2, bus.id_use_rs1, bus.id_use_rs2};
    mem_d = bus.mem_busy ? mem_q : ex_q;
    wb_d  = bus.mem_busy ? wb_q : mem_q;
    stall_cnt_d = (hz && stall_cnt_q != CMAX) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    flush_cnt_d = (fl && flush_cnt_q != CMAX) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: random stimulus into three configurations, scoreboarded against an instruction-level model.
module tb_pipe_hazard_ctrl;
  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
  } ins_t;
  typedef logic [42:0] out_t;
  logic clk = 1'b0;
  logic reset;
  ins_t cur;
  logic br, busy;
  int n_cmp = 0;
  int n_bad = 0;
  bit done = 0;
  always #5 clk = ~clk;
  pipe_hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) b0 ();
  pipe_hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) b1 ();
  pipe_hazard_ctrl_if #(.REG_AW(5), .CNT_W(2))  b2 ();
  `define HOOK(b) \
    assign b.id_valid = cur.v; assign b.id_rd = cur.rd; assign b.id_reg_write = cur.rw; \
    assign b.id_mem_read = cur.mr; assign b.id_rs1 = cur.rs1; assign b.id_rs2 = cur.rs2; \
    assign b.id_use_rs1 = cur.u1; assign b.id_use_rs2 = cur.u2; \
    assign b.ex_branch_taken = br; assign b.mem_busy = busy;
  `HOOK(b0)
  `HOOK(b1)
  `HOOK(b2)
  pipe_hazard_ctrl #(.REG_AW(5), .FWD_EN(1), .CNT_W(16)) u0 (.clk(clk), .reset(reset), .bus(b0));
  pipe_hazard_ctrl #(.REG_AW(5), .FWD_EN(0), .CNT_W(16)) u1 (.clk(clk), .reset(reset), .bus(b1));
  pipe_hazard_ctrl #(.REG_AW(5), .FWD_EN(1), .CNT_W(2))  u2 (.clk(clk), .reset(reset), .bus(b2));
  out_t act [3];
  assign act[0] = {b0.stall_if, b0.stall_id, b0.bubble_ex, b0.flush_ifid, b0.flush_idex, b0.fwd_a, b0.fwd_b,
                   b0.id_byp_a, b0.id_byp_b, b0.stall_cnt, b0.flush_cnt};
  assign act[1] = {b1.stall_if, b1.stall_id, b1.bubble_ex, b1.flush_ifid, b1.flush_idex, b1.fwd_a, b1.fwd_b,
                   b1.id_byp_a, b1.id_byp_b, b1.stall_cnt, b1.flush_cnt};
  assign act[2] = {b2.stall_if, b2.stall_id, b2.bubble_ex, b2.flush_ifid, b2.flush_idex, b2.fwd_a, b2.fwd_b,
                   b2.id_byp_a, b2.id_byp_b, 14'd0, b2.stall_cnt, 14'd0, b2.flush_cnt};
  // model: in-flight instructions per configuration, oldest last (0=EX, 1=MEM, 2=WB)
  ins_t inflight [3][$];
  int stalls [3];
  int flushes [3];
  int fwd_en [3] = '{1, 0, 1};
  int cmax [3] = '{65535, 65535, 3};
  out_t expq [3][$];
  function automatic logic writes(input ins_t i);
    return i.v && i.rw && i.rd != 0;
  endfunction
  function automatic logic reads(input ins_t i, input logic [4:0] r);
    return (i.u1 && i.rs1 == r) || (i.u2 && i.rs2 == r);
  endfunction
  function automatic logic [1:0] src(input ins_t e, input ins_t m, input ins_t w, input logic u,
                                     input logic [4:0] rs);
    if (u && writes(m) && m.rd == rs) return 2'b10;
    if (u && writes(w) && w.rd == rs) return 2'b01;
    return 2'b00;
  endfunction
  task automatic model_clear();
    for (int m = 0; m < 3; m++) begin
      inflight[m] = '{ins_t'(0), ins_t'(0), ins_t'(0)};
      stalls[m] = 0;
      flushes[m] = 0;
    end
  endtask
  task automatic model_step();
    for (int m = 0; m < 3; m++) begin
      ins_t e, mm, w;
      logic hz, frz, fl, st;
      logic [1:0] fa, fb;
      e = inflight[m][0]; mm = inflight[m][1]; w = inflight[m][2];
      if (fwd_en[m] != 0)
        hz = cur.v && writes(e) && e.mr && reads(cur, e.rd);
      else
        hz = cur.v && ((writes(e) && reads(cur, e.rd)) || (writes(mm) && reads(cur, mm.rd)));
      frz = busy;
      fl  = !frz && br;
      st  = !frz && !br && hz;
      fa = fwd_en[m] != 0 ? src(e, mm, w, e.u1, e.rs1) : 2'b00;
      fb = fwd_en[m] != 0 ? src(e, mm, w, e.u2, e.rs2) : 2'b00;
      expq[m].push_back({frz || st, frz || st, st, fl, fl, fa, fb,
                         writes(w) && cur.u1 && w.rd == cur.rs1, writes(w) && cur.u2 && w.rd == cur.rs2,
                         16'(stalls[m]), 16'(flushes[m])});
      if (!frz) begin
        void'(inflight[m].pop_back());
        inflight[m].push_front((fl || st) ? ins_t'(0) : cur);
        if (st) stalls[m] = stalls[m] < cmax[m] ? stalls[m] + 1 : stalls[m];
        if (fl) flushes[m] = flushes[m] < cmax[m] ? flushes[m] + 1 : flushes[m];
      end
    end
    if (!reset) model_clear();
  endtask
  initial begin
    reset = 1'b0; cur = '0; br = 1'b0; busy = 1'b0;
    model_clear();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      reset = (c < 2 || $urandom_range(0, 99) < 1) ? 1'b0 : 1'b1;
      cur.v   = $urandom_range(0, 99) < 85;
      cur.rd  = 5'($urandom_range(0, 3));
      cur.rs1 = 5'($urandom_range(0, 3));
      cur.rs2 = 5'($urandom_range(0, 3));
      cur.rw  = $urandom_range(0, 99) < 80;
      cur.mr  = $urandom_range(0, 99) < 40;
      cur.u1  = $urandom_range(0, 99) < 75;
      cur.u2  = $urandom_range(0, 99) < 60;
      br      = $urandom_range(0, 99) < 10;
      busy    = $urandom_range(0, 99) < 12;
      #1;
      model_step();
    end
    @(negedge clk);
    #3;
    done = 1;
    for (int m = 0; m < 3; m++) begin
      n_cmp++;
      if (expq[m].size() != 0) begin
        n_bad++;
        $display("FAIL drain dut%0d: %0d expected responses never compared, required 0", m, expq[m].size());
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    while (!done) begin
      @(negedge clk);
      #2;
      for (int m = 0; m < 3; m++) begin
        if (expq[m].size() != 0) begin
          out_t e;
          e = expq[m].pop_front();
          n_cmp++;
          if (act[m] !== e) begin
            n_bad++;
            $display("FAIL outputs dut%0d @%0t: got ctl=%b fa=%b fb=%b byp=%b sc=%0d fc=%0d, need ctl=%b fa=%b fb=%b byp=%b sc=%0d fc=%0d",
                     m, $time, act[m][42:38], act[m][37:36], act[m][35:34], act[m][33:32], act[m][31:16], act[m][15:0],
                     e[42:38], e[37:36], e[35:34], e[33:32], e[31:16], e[15:0]);
          end
        end
      end
    end
  end
endmodule
